// File: rtl/password_programmer_if.sv
// Write port of the shared password memory: the programmer drives requests,
// the memory answers with a per-cycle ready.
interface password_programmer_if #(
    parameter int ADDR_W  = 3,
    parameter int DIGIT_W = 4
);
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [DIGIT_W-1:0] wr_data;
    logic               wr_ready;

    modport master (output wr_en, output wr_addr, output wr_data, input wr_ready);
    modport slave  (input wr_en, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/password_programmer.sv
// Enrols a new DIGITS-digit password and writes it into the password store.
// Define PSD_CONFIRM_EN to require a matching second entry before any write.
module password_programmer #(
    parameter int DIGITS    = 4,
    parameter int DIGIT_W   = 4,
    parameter int ADDR_W    = 3,
    parameter int BASE_ADDR = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               access_allowed,
    input  logic               program_req,
    input  logic               button_push,
    input  logic [DIGIT_W-1:0] toggle_switch,
    password_programmer_if.master wr,
    output logic [DIGIT_W-1:0] psd,
    output logic               prog_busy,
    output logic               prog_done,
    output logic               prog_error
);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ENTER   = 3'd1,
`ifdef PSD_CONFIRM_EN
        CONFIRM = 3'd2,
`endif
        WRITE   = 3'd3,
        DONE    = 3'd4,
        ERROR   = 3'd5
    } state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   idx, idx_inc;
    logic [DIGIT_W-1:0] digit_buf [DIGITS];
    logic               btn_prev;
    logic               btn_edge;
    logic               last_digit;

    assign btn_edge   = button_push && !btn_prev;
    assign last_digit = (idx == LAST_IDX);
    assign idx_inc    = last_digit ? '0 : idx + IDX_W'(1);

`ifdef PSD_CONFIRM_EN
    logic mismatch;
    logic digit_diff;
    assign digit_diff = (toggle_switch != digit_buf[idx]);
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Abort on loss of access is checked before the button, so a
    // simultaneous edge is discarded.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (program_req && access_allowed) state_nxt = ENTER;
            ENTER: begin
                if (!access_allowed) state_nxt = ERROR;
`ifdef PSD_CONFIRM_EN
                else if (btn_edge && last_digit) state_nxt = CONFIRM;
`else
                else if (btn_edge && last_digit) state_nxt = WRITE;
`endif
            end
`ifdef PSD_CONFIRM_EN
            CONFIRM: begin
                if (!access_allowed) state_nxt = ERROR;
                else if (btn_edge && last_digit)
                    state_nxt = (mismatch || digit_diff) ? ERROR : WRITE;
            end
`endif
            WRITE:   if (wr.wr_ready && last_digit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            ERROR:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx      <= '0;
            psd      <= '0;
            btn_prev <= 1'b0;
            for (int i = 0; i < DIGITS; i++) digit_buf[i] <= '0;
`ifdef PSD_CONFIRM_EN
            mismatch <= 1'b0;
`endif
        end else begin
            btn_prev <= button_push;
            case (state)
                IDLE: begin
                    idx <= '0;
`ifdef PSD_CONFIRM_EN
                    mismatch <= 1'b0;
`endif
                end
                ENTER: if (access_allowed && btn_edge) begin
                    digit_buf[idx] <= toggle_switch;
                    psd            <= toggle_switch;
                    idx            <= idx_inc;
                end
`ifdef PSD_CONFIRM_EN
                CONFIRM: if (access_allowed && btn_edge) begin
                    mismatch <= mismatch || digit_diff;
                    psd      <= toggle_switch;
                    idx      <= idx_inc;
                end
`endif
                WRITE: if (wr.wr_ready) idx <= idx_inc;
                default: ;
            endcase
        end
    end

    // Address and data are held at zero outside WRITE so the port is quiet.
    always_comb begin
        wr.wr_en   = (state == WRITE);
        wr.wr_addr = '0;
        wr.wr_data = '0;
        if (state == WRITE) begin
            wr.wr_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(idx);
            wr.wr_data = digit_buf[idx];
        end
        prog_busy  = (state != IDLE);
        prog_done  = (state == DONE);
        prog_error = (state == ERROR);
    end
endmodule

// File: tb/tb_password_programmer.sv
// Randomised bench for password_programmer against a digit-list reference model.
`timescale 1ns/1ps
module tb_password_programmer;
    localparam int DIGITS    = 4;
    localparam int DIGIT_W   = 4;
    localparam int ADDR_W    = 3;
    localparam int BASE_ADDR = 0;
`ifdef PSD_CONFIRM_EN
    localparam bit CONF = 1'b1;
`else
    localparam bit CONF = 1'b0;
`endif

    typedef logic [3:0] digs_t [DIGITS];

    logic       clk = 1'b0;
    logic       rst;
    logic       access_allowed;
    logic       program_req;
    logic       button_push;
    logic [3:0] toggle_switch;
    logic [3:0] psd;
    logic       prog_busy, prog_done, prog_error;

    password_programmer_if #(.ADDR_W(ADDR_W), .DIGIT_W(DIGIT_W)) wr ();

    password_programmer #(
        .DIGITS(DIGITS), .DIGIT_W(DIGIT_W), .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)
    ) dut (
        .clk(clk), .rst(rst), .access_allowed(access_allowed),
        .program_req(program_req), .button_push(button_push),
        .toggle_switch(toggle_switch), .wr(wr), .psd(psd),
        .prog_busy(prog_busy), .prog_done(prog_done), .prog_error(prog_error)
    );

    always #5 clk = ~clk;

    int checks;
    int failures;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory-side observer: records accepted writes and pulse counts.
    int         cyc, done_cnt, err_cnt, wr_cycles, stall_seen, stall_bad, last_wr_cyc, done_cyc;
    logic [3:0] mem [8];
    logic [6:0] wlog [$];
    logic       prev_stall;
    logic [2:0] prev_addr;
    logic [3:0] prev_data;

    always @(negedge clk) begin
        cyc++;
        if (prog_done === 1'b1) begin done_cnt++; done_cyc = cyc; end
        if (prog_error === 1'b1) err_cnt++;
        if (wr.wr_en === 1'b1) begin
            wr_cycles++;
            if (prev_stall) begin
                stall_seen++;
                if (wr.wr_addr !== prev_addr || wr.wr_data !== prev_data) stall_bad++;
            end
            if (wr.wr_ready === 1'b1) begin
                wlog.push_back({wr.wr_addr, wr.wr_data});
                mem[wr.wr_addr] = wr.wr_data;
                last_wr_cyc = cyc;
            end
        end
        prev_stall = (wr.wr_en === 1'b1) && (wr.wr_ready !== 1'b1);
        prev_addr  = wr.wr_addr;
        prev_data  = wr.wr_data;
    end

    // Memory ready: 0 = always ready, 1 = random, 2 = pattern over write cycles.
    int ready_mode;
    int pi;
    bit pat [7];

    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0: wr.wr_ready = 1'b1;
            1: wr.wr_ready = 1'($urandom_range(0, 1));
            2: begin
                if (wr.wr_en === 1'b1) begin
                    wr.wr_ready = pat[pi % 7];
                    pi++;
                end else begin
                    wr.wr_ready = 1'b0;
                end
            end
            default: wr.wr_ready = 1'b0;
        endcase
        if (ready_mode != 2) pi = 0;
    end

    logic [3:0] exp_mem [8];

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [3:0] d, input int hold);
        toggle_switch = d;
        button_push   = 1'b1;
        repeat (hold) tick();
        button_push = 1'b0;
        tick();
    endtask

    task automatic start();
        program_req = 1'b1;
        tick();
        program_req = 1'b0;
    endtask

    task automatic wait_end(input int d0, input int e0, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (done_cnt != d0 || err_cnt != e0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) tick();
    endtask

    // Reference: a successful enrolment writes digit i to BASE_ADDR+i in order,
    // once each; a confirm mismatch writes nothing and pulses prog_error.
    task automatic enrol(input digs_t a, input digs_t b, input int hold, input string tag);
        int d0, e0, w0, c0, s0, nw;
        bit ok, match;
        logic [6:0] e;
        logic [3:0] exp_psd;
        d0 = done_cnt; e0 = err_cnt; w0 = wlog.size(); c0 = wr_cycles; s0 = stall_seen;
        start();
        for (int i = 0; i < DIGITS; i++) push(a[i], hold);
        match = 1'b1;
        exp_psd = a[DIGITS-1];
        if (CONF) begin
            for (int i = 0; i < DIGITS; i++) push(b[i], 1);
            for (int i = 0; i < DIGITS; i++) if (a[i] != b[i]) match = 1'b0;
            exp_psd = b[DIGITS-1];
        end
        wait_end(d0, e0, ok);
        check({tag, "_finished"}, 32'(ok), 32'd1);
        check({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'(match ? 1 : 0));
        check({tag, "_error_pulses"}, 32'(err_cnt - e0), 32'(match ? 0 : 1));
        nw = wlog.size() - w0;
        check({tag, "_write_count"}, 32'(nw), 32'(match ? DIGITS : 0));
        if (match) begin
            for (int i = 0; i < DIGITS && i < nw; i++) begin
                e = wlog[w0 + i];
                check({tag, "_addr"}, 32'(e[6:4]), 32'((BASE_ADDR + i) % 8));
                check({tag, "_data"}, 32'(e[3:0]), 32'(a[i]));
            end
            for (int i = 0; i < DIGITS; i++) exp_mem[(BASE_ADDR + i) % 8] = a[i];
            if (ready_mode == 0) begin
                check({tag, "_wr_en_cycles"}, 32'(wr_cycles - c0), 32'(DIGITS));
                check({tag, "_done_latency"}, 32'(done_cyc - last_wr_cyc), 32'd1);
            end
            if (ready_mode == 2)
                check({tag, "_stalls_seen"}, 32'(stall_seen > s0), 32'd1);
        end
        check({tag, "_stall_stable"}, 32'(stall_bad), 32'd0);
        check({tag, "_psd"}, 32'(psd), 32'(exp_psd));
        check({tag, "_busy_after"}, 32'(prog_busy), 32'd0);
    endtask

    digs_t a, b;
    int    w0, e0;
    bit    hit;

    initial begin
        rst = 1'b1; access_allowed = 1'b0; program_req = 1'b0;
        button_push = 1'b0; toggle_switch = 4'd0; ready_mode = 0;
        for (int i = 0; i < 7; i++) pat[i] = 1'b0;
        repeat (3) tick();
        check("rst_wr_en", 32'(wr.wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr.wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr.wr_data), 32'd0);
        check("rst_psd", 32'(psd), 32'd0);
        check("rst_busy", 32'(prog_busy), 32'd0);
        check("rst_done", 32'(prog_done), 32'd0);
        check("rst_error", 32'(prog_error), 32'd0);
        rst = 1'b0;
        tick();

        program_req = 1'b1; tick(); program_req = 1'b0; tick();
        check("req_without_access", 32'(prog_busy), 32'd0);
        access_allowed = 1'b1;
        tick();

        a = '{4'd4, 4'd7, 4'd9, 4'd1};
        enrol(a, a, 1, "basic");

        b = '{4'd4, 4'd7, 4'd8, 4'd1};
        enrol(a, b, 1, "confirm_mismatch");

        a = '{4'd5, 4'd2, 4'd3, 4'd6};
        enrol(a, a, 10, "held_button");

        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        ready_mode = 2;
        a = '{4'd8, 4'd0, 4'd15, 4'd3};
        enrol(a, a, 1, "stall_pattern");
        ready_mode = 0;

        // Abort after two digits.
        w0 = wlog.size(); e0 = err_cnt;
        start();
        push(4'd1, 1);
        push(4'd2, 1);
        access_allowed = 1'b0;
        tick();
        check("abort_error_next", 32'(prog_error), 32'd1);
        repeat (3) tick();
        check("abort_error_pulses", 32'(err_cnt - e0), 32'd1);
        check("abort_no_writes", 32'(wlog.size() - w0), 32'd0);
        check("abort_idle", 32'(prog_busy), 32'd0);
        access_allowed = 1'b1;
        tick();
        a = '{4'd2, 4'd2, 4'd6, 4'd9};
        enrol(a, a, 2, "after_abort");

        // Button edge on the final digit together with access falling.
        w0 = wlog.size(); e0 = err_cnt;
        start();
        push(4'd3, 1);
        push(4'd4, 1);
        push(4'd5, 1);
        toggle_switch = 4'd9;
        button_push = 1'b1;
        access_allowed = 1'b0;
        tick();
        check("simul_error", 32'(prog_error), 32'd1);
        button_push = 1'b0;
        repeat (3) tick();
        check("simul_no_writes", 32'(wlog.size() - w0), 32'd0);
        check("simul_error_pulses", 32'(err_cnt - e0), 32'd1);
        check("simul_psd_discarded", 32'(psd), 32'd5);
        access_allowed = 1'b1;
        tick();

        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < DIGITS; i++) a[i] = 4'($urandom_range(0, 15));
            b = a;
            if ($urandom_range(0, 2) == 0) b[$urandom_range(0, DIGITS - 1)] ^= 4'd1;
            ready_mode = int'($urandom_range(0, 1));
            enrol(a, b, int'($urandom_range(1, 3)), "random");
        end
        ready_mode = 0;

        // Reset while the third write is stalled.
        pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        ready_mode = 2;
        w0 = wlog.size();
        a = '{4'd11, 4'd12, 4'd13, 4'd14};
        start();
        for (int i = 0; i < DIGITS; i++) push(a[i], 1);
        if (CONF) for (int i = 0; i < DIGITS; i++) push(a[i], 1);
        hit = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (wlog.size() == w0 + 2) begin hit = 1'b1; break; end
            tick();
        end
        check("midwrite_reached", 32'(hit), 32'd1);
        rst = 1'b1;
        tick();
        check("midwrite_rst_wr_en", 32'(wr.wr_en), 32'd0);
        check("midwrite_rst_busy", 32'(prog_busy), 32'd0);
        check("midwrite_rst_psd", 32'(psd), 32'd0);
        check("midwrite_rst_addr", 32'(wr.wr_addr), 32'd0);
        rst = 1'b0;
        ready_mode = 0;
        repeat (2) tick();
        check("midwrite_write_count", 32'(wlog.size() - w0), 32'd2);
        exp_mem[(BASE_ADDR + 0) % 8] = a[0];
        exp_mem[(BASE_ADDR + 1) % 8] = a[1];
        for (int i = 0; i < DIGITS; i++)
            check("midwrite_mem", 32'(mem[(BASE_ADDR + i) % 8]), 32'(exp_mem[(BASE_ADDR + i) % 8]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/password_programmer.md
Name: password_programmer

Overview:
- Writer-side companion to the ROM/RAM-based password checker: lets an authenticated user enrol a new N-digit password.
- Digits are entered on toggle_switch and captured on button_push rising edges, optionally confirmed by re-entry, then written digit-by-digit into the password store over a simple write handshake.
- Sits beside the access controller. It is gated by that controller's access_allowed and drives the write port of the shared password memory.

Parameters:
- DIGITS, 4, number of password digits per entry (1..8)
- DIGIT_W, 4, bits per digit; matches toggle_switch width
- ADDR_W, 3, password memory address width
- BASE_ADDR, 0, memory address of digit 0; digit i goes to BASE_ADDR+i (mod 2^ADDR_W)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- access_allowed  in  1  level from access controller; enrolment permitted only while 1
- program_req  in  1  start enrolment; sampled in IDLE only
- button_push  in  1  digit-enter button, already debounced, level
- toggle_switch  in  DIGIT_W  digit value
- wr_ready  in  1  memory accepts write in the current cycle
- wr_en  out  1  write request
- wr_addr  out  ADDR_W  write address
- wr_data  out  DIGIT_W  write data
- psd  out  DIGIT_W  echo of last captured digit, for the display
- prog_busy  out  1  high in any state other than IDLE
- prog_done  out  1  one-cycle pulse when all digits are written
- prog_error  out  1  one-cycle pulse on confirm mismatch or abort

Behaviour:
- Reset (rst=1 at posedge) sets:
  - state=IDLE; all outputs 0; psd=0; digit index=0; buffer cleared; button edge register=0.
- Button edge detection:
  - A digit is captured only on a button_push 0->1 transition, detected against a registered previous sample.
  - Holding the button captures exactly one digit.
- IDLE:
  - If program_req=1 and access_allowed=1, go to ENTER with idx=0.
  - Otherwise stay in IDLE; program_req is ignored in every other state.
- ENTER:
  - Each button edge stores toggle_switch into buf[idx], sets psd to that value and increments idx.
  - After digit DIGITS-1 is captured, go to CONFIRM (macro defined) or WRITE (macro undefined), with idx=0.
- CONFIRM:
  - Each button edge compares toggle_switch with buf[idx] and sets a sticky mismatch flag if they differ; psd is updated.
  - After the last digit: mismatch=0 goes to WRITE; mismatch=1 goes to ERROR.
- WRITE:
  - wr_en=1, wr_addr=BASE_ADDR+idx, wr_data=buf[idx], all driven from registers.
  - A write completes in a cycle where wr_en=1 and wr_ready=1; idx increments the next cycle.
  - After the last accepted write: wr_en=0 and go to DONE.
  - Stalls indefinitely while wr_ready=0.
  - Ignores access_allowed and button_push, so the store always receives all DIGITS writes once WRITE is entered.
- DONE: prog_done=1 for one cycle, then IDLE.
- ERROR: prog_error=1 for one cycle, then IDLE; no writes are issued.
- Abort: if access_allowed falls in ENTER or CONFIRM, go to ERROR next cycle with no writes.
- Simultaneous events:
  - A button edge in the same cycle as access_allowed falling: the abort wins and the digit is discarded.
- Reset mid-WRITE: wr_en is 0 after the reset edge. Digits already accepted stay in memory; the store may hold a mixed password, and the checker owner must re-enrol.
- Latency:
  - Last confirm digit edge to first wr_en: 1 cycle.
  - With wr_ready tied high: DIGITS cycles of wr_en, then prog_done on the next cycle.

Optional Feature:
- Macro: PSD_CONFIRM_EN.
- Defined: CONFIRM state present; the password must be entered twice, and a mismatch gives prog_error with no writes.
- Undefined: CONFIRM state and mismatch logic are removed; ENTER goes straight to WRITE, and prog_error arises only from abort.

Test Plan:
1. Macro on, wr_ready=1, access_allowed=1, program_req pulse. Enter digits 4,7,9,1, then confirm 4,7,9,1. Expect:
   - wr_en high exactly 4 cycles, addr 0..3, data 4,7,9,1;
   - prog_done one pulse;
   - prog_busy low afterwards.
2. Macro on, enter 4,7,9,1, confirm 4,7,8,1. Expect prog_error one pulse, wr_en never asserted, state returns to IDLE.
3. Hold button_push high for 10 cycles while entering digit 5. Expect buf[0]=5 only and idx=1; no extra captures.
4. Drop access_allowed after 2 digits are entered. Expect prog_error next cycle, no wr_en, a subsequent program_req is accepted again.
5. In WRITE, toggle wr_ready 1,0,0,1,1,0,1. Expect each digit written exactly once in order, and wr_addr/wr_data stable while stalled.
6. Assert rst during the third write. Expect all outputs 0 on the next cycle; memory holds new digits 0..1 plus old digits 2..3.
